sseg_scan_capture: RTL
======================

// Module: sseg_scan_capture
// PURPOSE
//  Readback end of the seven-segment display path: samples a multiplexed, active-low
//  abcdefg segment bus plus one-hot digit strobes and recovers the hex word and sign.
//  Each digit pattern must be stable for STABLE_CYCLES samples before it is decoded.
//  A complete frame is presented through a one-entry valid/ready buffer.
//  Used for display self-check and for the processor's display readback register.
// PARAMETERS
//  DIGITS         4   number of multiplexed digits (dig_sel width); out_value = 4*DIGITS bits
//  STABLE_CYCLES  4   consecutive identical samples required to capture a digit (>=2)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  seg_in     in   7          active-low segments, [6]=a ... [0]=g
//  dig_sel    in   DIGITS     one-hot digit strobe; bit i = digit i (digit 0 = LS nibble)
//  neg_in     in   7          active-low sign-digit segments
//  out_ready  in   1          consumer accepts the frame when out_valid & out_ready
//  out_valid  out  1          frame available
//  out_value  out  4*DIGITS   decoded hex word
//  out_neg    out  1          sign: 1 = minus shown
//  out_err    out  1          frame contained an undecodable digit or sign pattern
//  out_ovr    out  1          one-cycle pulse: completed frame dropped, buffer full
// BEHAVIOUR
//  Reset: all outputs 0; stability counter, last sample, capture mask, digit regs, err cleared.
//  Decode (seg_in -> nibble): 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//   0100000=6 0001111=7 0000000=8 0000100=9 0001000=A 1100000=b 0110001=C 1000010=d
//   0110000=E 0111000=F. Any other pattern: nibble 0, sets the frame error bit.
//  Sign (neg_in): 1111111 -> neg 0; 1111110 -> neg 1; other -> neg 0 plus frame error.
//  Stability:
//   - Sample = {dig_sel, seg_in}, registered every cycle.
//   - Counter resets to 0 when sample != last sample or dig_sel not one-hot.
//   - Otherwise counter increments, saturating at STABLE_CYCLES-1.
//  Capture:
//   - Occurs on the edge where the counter goes STABLE_CYCLES-2 -> STABLE_CYCLES-1.
//   - Exactly once per stable run; a held pattern is never re-captured.
//   - Writes the digit nibble, sets the mask bit, and ORs in the decode error.
//   - Recapturing an already-masked digit before frame completion overwrites it.
//  Latency: a pattern first sampled at edge k is captured at edge k+STABLE_CYCLES-1.
//  Blank (dig_sel==0) or multi-hot dig_sel: no capture; counter held at 0; mask unchanged.
//  FSM, 2 states:
//   COLLECT: frame completes on the capture edge when (mask | new bit) == all ones.
//    - Buffer empty, or out_ready high that cycle: load out_value, out_err, out_neg
//      (neg_in sampled that edge); out_valid=1; go PRESENT.
//    - Buffer full, not ready: discard frame; pulse out_ovr.
//    - In every completion case: clear mask and frame error.
//   PRESENT: out_valid=1; outputs held stable. Collection continues.
//    - out_ready=1 with no same-edge completion: out_valid=0 next edge; go COLLECT.
//  Simultaneous accept and completion: new frame loads; out_valid stays 1; no ovr.
//  Reset mid-frame: partial mask and buffer discarded immediately (async).
//  out_ready ignored while out_valid=0.
// TESTING
//  1. DIGITS=4, STABLE=4: scan 1,2,3,4 (digits 0..3), 4 cycles each, neg 1111111, ready=1
//     -> out_valid one cycle after the digit-3 capture; out_value=16'h4321, neg=0, err=0.
//  2. Digit 2 held 3 cycles, then glitch -> no capture, no frame.
//     Rescan digit 2 for 4 cycles -> frame completes.
//  3. Digit 1 shows 1111111; neg_in=1111110 -> frame with nibble1=0, out_err=1, out_neg=1.
//  4. ready=0 across two full frames -> first frame held unchanged; out_ovr pulses once.
//     ready=1 then -> single transfer; out_valid drops.
//  5. ready=1 on the same edge a new frame completes -> back-to-back frames, valid stays 1.
//  6. dig_sel=4'b0110 for 10 cycles -> no capture.
//     rst_n low mid-frame -> all outputs 0 with no clock edge.

Source files
------------

// File: rtl/sseg_scan_capture_if.sv
// Frame readback port of the seven-segment capture block.
// The capture block is the master; the consumer of decoded frames is the slave.
interface sseg_scan_capture_if #(
  parameter int DIGITS = 4
);
  logic                  out_ready;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_value;
  logic                  out_neg;
  logic                  out_err;
  logic                  out_ovr;

  modport master (
    input  out_ready,
    output out_valid, out_value, out_neg, out_err, out_ovr
  );

  modport slave (
    output out_ready,
    input  out_valid, out_value, out_neg, out_err, out_ovr
  );
endinterface

// File: rtl/sseg_scan_capture.sv
// Recovers the hex word and sign from a multiplexed active-low seven-segment bus.
// Debounces each digit pattern, then presents whole frames through a one-entry buffer.
module sseg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [DIGITS-1:0] dig_sel,
  input  logic [6:0]        neg_in,
  sseg_scan_capture_if.master frame
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 2);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [DIGITS+6:0]   last_q;
  logic [CW-1:0]       cnt_q;
  logic [DIGITS-1:0]   mask_q;
  logic [4*DIGITS-1:0] digits_q;
  logic                err_q;
  logic [0:0]          state_q;

  logic                onehot, same, capture, complete, load, accept;
  logic [4:0]          dec;
  logic                neg_val, neg_bad;
  logic [DIGITS-1:0]   mask_next;
  logic [4*DIGITS-1:0] digits_next;

  // Result is {error, nibble}; unknown patterns decode to 0 with the error bit set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode_seg = 5'h00;
      7'b1001111: decode_seg = 5'h01;
      7'b0010010: decode_seg = 5'h02;
      7'b0000110: decode_seg = 5'h03;
      7'b1001100: decode_seg = 5'h04;
      7'b0100100: decode_seg = 5'h05;
      7'b0100000: decode_seg = 5'h06;
      7'b0001111: decode_seg = 5'h07;
      7'b0000000: decode_seg = 5'h08;
      7'b0000100: decode_seg = 5'h09;
      7'b0001000: decode_seg = 5'h0A;
      7'b1100000: decode_seg = 5'h0B;
      7'b0110001: decode_seg = 5'h0C;
      7'b1000010: decode_seg = 5'h0D;
      7'b0110000: decode_seg = 5'h0E;
      7'b0111000: decode_seg = 5'h0F;
      default:    decode_seg = 5'h10;
    endcase
  endfunction

  always_comb begin
    onehot      = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    same        = ({dig_sel, seg_in} == last_q);
    capture     = onehot && same && (cnt_q == CNT_CAP);
    dec         = decode_seg(seg_in);
    mask_next   = mask_q | dig_sel;
    complete    = capture && (mask_next == '1);
    accept      = (state_q == PRESENT) && frame.out_ready;
    load        = complete && ((state_q == COLLECT) || frame.out_ready);
    neg_val     = (neg_in == 7'b1111110);
    neg_bad     = (neg_in != 7'b1111111) && (neg_in != 7'b1111110);
    digits_next = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) digits_next[4*i +: 4] = dec[3:0];
    end
  end

  // Saturating counter stops at its top value so a held pattern captures only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= {dig_sel, seg_in};
      if (!onehot || !same)   cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else if (capture) begin
      digits_q <= digits_next;
      if (complete) begin
        mask_q <= '0;
        err_q  <= 1'b0;
      end else begin
        mask_q <= mask_next;
        err_q  <= err_q | dec[4];
      end
    end
  end

  // A completed frame overwrites the buffer only if it is empty or being drained this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= COLLECT;
      frame.out_value <= '0;
      frame.out_neg   <= 1'b0;
      frame.out_err   <= 1'b0;
      frame.out_ovr   <= 1'b0;
    end else begin
      frame.out_ovr <= 1'b0;
      if (load) begin
        frame.out_value <= digits_next;
        frame.out_err   <= err_q | dec[4] | neg_bad;
        frame.out_neg   <= neg_val;
        state_q         <= PRESENT;
      end else if (complete) begin
        frame.out_ovr <= 1'b1;
      end else if (accept) begin
        state_q <= COLLECT;
      end
    end
  end

  assign frame.out_valid = (state_q == PRESENT);

endmodule
